// File: rtl/uart_ch_arb.sv
// uart_ch_arb: round-robin scheduler sharing one UART formatter/TX path among NUM_CH sample producers
module uart_ch_arb #(
  parameter int NUM_CH      = 4,
  parameter int FRAME_CHARS = 3,
  parameter int TIMEOUT     = 20000
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [NUM_CH-1:0]           req,
  input  logic [8*NUM_CH-1:0]         req_data,
  input  logic                        tx_stop,
  input  logic                        ovf_clr,
  output logic                        start,
  output logic [7:0]                  adc_data,
  output logic [$clog2(NUM_CH)-1:0]   ch_sel,
  output logic                        busy,
  output logic [NUM_CH-1:0]           ovf,
  output logic                        err
);
  localparam int CW  = $clog2(NUM_CH);
  localparam int CNW = $clog2(FRAME_CHARS) + 1;
  localparam int TW  = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t            state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d, ovf_q, ovf_d;
  logic [7:0]        pend_data_q [NUM_CH];
  logic [7:0]        pend_data_d [NUM_CH];
  logic [CW-1:0]     ptr_q, ptr_d, ch_sel_q, ch_sel_d, win, ch_next;
  logic [CNW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        adc_q, adc_d;
  logic              start_q, start_d, busy_q, busy_d, err_q, err_d;
  logic              found, grant;
  logic [CW:0]       idx;
  assign start    = start_q;
  assign adc_data = adc_q;
  assign ch_sel   = ch_sel_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;
  assign err      = err_q;
  assign ch_next  = (ch_sel_q == CW'(NUM_CH - 1)) ? '0 : ch_sel_q + CW'(1);
  // first pending channel at or after ptr, scanning downward so the closest one wins
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (CW+1)'(k);
      idx = (idx >= (CW+1)'(NUM_CH)) ? idx - (CW+1)'(NUM_CH) : idx;
      if (pend_q[idx[CW-1:0]]) begin
        win   = idx[CW-1:0];
        found = 1'b1;
      end
    end
  end
  // pending buffers, grant, frame character counting and stall timeout
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_clr ? '0 : ovf_q;
    ptr_d       = ptr_q;
    ch_sel_d    = ch_sel_q;
    adc_d       = adc_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    err_d       = 1'b0;
    start_d     = (state_q == START);
    grant       = (state_q == IDLE) && found;
    if (grant) begin
      pend_d[win] = 1'b0;
      adc_d       = pend_data_q[win];
      ch_sel_d    = win;
      busy_d      = 1'b1;
      state_d     = START;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (req[i]) begin
        if (pend_q[i] && !(grant && win == CW'(i))) ovf_d[i] = 1'b1;
        pend_d[i]      = 1'b1;
        pend_data_d[i] = req_data[8*i +: 8];
      end
    end
    case (state_q)
      START: begin
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_stop) begin
          if (cnt_q == CNW'(FRAME_CHARS - 1)) begin
            busy_d  = 1'b0;
            ptr_d   = ch_next;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNW'(1);
            tmo_d = '0;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          ptr_d   = ch_next;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end
  // state register with asynchronous reset
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      pend_data_q <= '{default: '0};
      ovf_q       <= '0;
      ptr_q       <= '0;
      ch_sel_q    <= '0;
      adc_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      ch_sel_q    <= ch_sel_d;
      adc_q       <= adc_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      start_q     <= start_d;
    end
  end
endmodule
